// File: rtl/unidade_mult_div_if.sv
// Request/response bundle between the register bank read ports and the multiply/divide unit.
// master drives operands and start; slave returns status and the HI/LO results.
interface unidade_mult_div_if #(
    parameter int unsigned LARGURA = 32
);
    logic               iniciar;
    logic [1:0]         operacao;
    logic [LARGURA-1:0] Rs;
    logic [LARGURA-1:0] Rt;
    logic               ocupado;
    logic               pronto;
    logic [LARGURA-1:0] HI;
    logic [LARGURA-1:0] LO;
    logic               erro_div_zero;

    modport master (
        output iniciar, operacao, Rs, Rt,
        input  ocupado, pronto, HI, LO, erro_div_zero
    );

    modport slave (
        input  iniciar, operacao, Rs, Rt,
        output ocupado, pronto, HI, LO, erro_div_zero
    );
endinterface

// File: rtl/unidade_mult_div.sv
// Multi-cycle 32-bit multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, signs applied in a final adjust step, results held in HI/LO.
module unidade_mult_div #(
    parameter int unsigned LARGURA = 32
) (
    input logic              clock,
    input logic              reset,
    unidade_mult_div_if.slave bus
);
    localparam int unsigned W = LARGURA;

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] CALCULA = 2'd1;
    localparam logic [1:0] AJUSTA  = 2'd2;

    logic [1:0]     estado_q, estado_d;
    logic [4:0]     cont_q, cont_d;
    logic           div_q, div_d;
    logic           neg_res_q, neg_res_d;
    logic           neg_rem_q, neg_rem_d;
    logic [W-1:0]   b_q, b_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           ocupado_q, ocupado_d;
    logic           pronto_q, pronto_d;
    logic           erro_q, erro_d;

    logic           com_sinal;
    logic [W-1:0]   abs_a, abs_b;
    logic [W:0]     soma, rem_desl, dif;

    always_comb begin
        estado_d  = estado_q;
        cont_d    = cont_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_d       = b_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        ocupado_d = ocupado_q;
        pronto_d  = 1'b0;
        erro_d    = erro_q;

        com_sinal = ~bus.operacao[0];
        abs_a     = (com_sinal && bus.Rs[W-1]) ? -bus.Rs : bus.Rs;
        abs_b     = (com_sinal && bus.Rt[W-1]) ? -bus.Rt : bus.Rt;

        // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
        soma     = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
        rem_desl = {acc_q[2*W-1:W], acc_q[W-1]};
        dif      = rem_desl - {1'b0, b_q};

        case (estado_q)
            OCIOSO: begin
                if (bus.iniciar) begin
                    if (bus.operacao[1] && (bus.Rt == '0)) begin
                        hi_d     = bus.Rs;
                        lo_d     = '1;
                        pronto_d = 1'b1;
                        erro_d   = 1'b1;
                    end else begin
                        div_d     = bus.operacao[1];
                        b_d       = abs_b;
                        acc_d     = {{W{1'b0}}, abs_a};
                        neg_res_d = com_sinal & (bus.Rs[W-1] ^ bus.Rt[W-1]);
                        neg_rem_d = com_sinal & bus.operacao[1] & bus.Rs[W-1];
                        cont_d    = '0;
                        ocupado_d = 1'b1;
                        estado_d  = CALCULA;
                    end
                end
            end
            CALCULA: begin
                if (div_q) begin
                    // borrow out of the trial subtract means restore
                    acc_d = dif[W] ? {rem_desl[W-1:0], acc_q[W-2:0], 1'b0}
                                   : {dif[W-1:0], acc_q[W-2:0], 1'b1};
                end else begin
                    acc_d = {soma, acc_q[W-1:1]};
                end
                cont_d = cont_q + 5'd1;
                if (cont_q == 5'(W - 1)) begin
                    estado_d = AJUSTA;
                end
            end
            AJUSTA: begin
                if (div_q) begin
                    lo_d = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
                    hi_d = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
                end else begin
                    {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                end
                pronto_d  = 1'b1;
                erro_d    = 1'b0;
                ocupado_d = 1'b0;
                estado_d  = OCIOSO;
            end
            default: begin
                ocupado_d = 1'b0;
                estado_d  = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            cont_q    <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_q       <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cont_q    <= cont_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
            erro_q    <= erro_d;
        end
    end

    assign bus.ocupado       = ocupado_q;
    assign bus.pronto        = pronto_q;
    assign bus.HI            = hi_q;
    assign bus.LO            = lo_q;
    assign bus.erro_div_zero = erro_q;
endmodule

// File: tb/tb_unidade_mult_div.sv
// Directed bench for unidade_mult_div: latency, results, divide-by-zero, ignored restarts
// and mid-operation reset. Inputs change and outputs are sampled on the falling edge.
module tb_unidade_mult_div;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    unidade_mult_div_if #(.LARGURA(32)) bus ();

    unidade_mult_div #(.LARGURA(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Caller sits at a falling edge; returns at the falling edge right after the start edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.iniciar  = 1'b1;
        bus.operacao = op;
        bus.Rs       = a;
        bus.Rt       = b;
        @(negedge clock);
        bus.iniciar  = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic saw_busy);
        lat      = 0;
        saw_busy = 1'b0;
        while (!bus.pronto && lat < 100) begin
            saw_busy = saw_busy | bus.ocupado;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.iniciar  = 1'b0;
        bus.operacao = 2'b00;
        bus.Rs       = '0;
        bus.Rt       = '0;
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if ({bus.HI, bus.LO} !== 64'd0) begin
            n_fail++; $display("FAIL reset_hilo: got %h expected 0", {bus.HI, bus.LO});
        end
        n_checks++;
        if ({bus.ocupado, bus.pronto, bus.erro_div_zero} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000",
                     {bus.ocupado, bus.pronto, bus.erro_div_zero});
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_multu_max();
        int   lat;
        logic busy;
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++;
        if (bus.ocupado !== 1'b1) begin
            n_fail++; $display("FAIL multu_busy: got %b expected 1", bus.ocupado);
        end
        wait_done(lat, busy);
        n_checks++;
        if (lat !== 33) begin
            n_fail++; $display("FAIL multu_latency: got %0d expected 33", lat);
        end
        n_checks++;
        if ({bus.HI, bus.LO} !== 64'hFFFF_FFFE_0000_0001) begin
            n_fail++;
            $display("FAIL multu_result: got %h expected fffffffe00000001", {bus.HI, bus.LO});
        end
        n_checks++;
        if ({bus.ocupado, bus.erro_div_zero} !== 2'b00) begin
            n_fail++;
            $display("FAIL multu_flags: got %b expected 00", {bus.ocupado, bus.erro_div_zero});
        end
        @(negedge clock);
        n_checks++;
        if (bus.pronto !== 1'b0) begin
            n_fail++; $display("FAIL pronto_pulse_width: got %b expected 0", bus.pronto);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic busy;
        start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, busy);
        n_checks++;
        if ({bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            n_fail++;
            $display("FAIL mult_neg: got %h expected ffffffffffffffeb", {bus.HI, bus.LO});
        end
        start_op(2'b11, 32'd100, 32'd7);
        wait_done(lat, busy);
        n_checks++;
        if (lat !== 33) begin
            n_fail++; $display("FAIL b2b_latency: got %0d expected 33", lat);
        end
        n_checks++;
        if ({bus.HI, bus.LO} !== {32'd2, 32'd14}) begin
            n_fail++;
            $display("FAIL divu_100_7: got %h expected 000000020000000e", {bus.HI, bus.LO});
        end
    endtask

    task automatic test_div_signed();
        int   lat;
        logic busy;
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, busy);
        n_checks++;
        if ({bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_neg7_2: got %h expected fffffffffffffffd", {bus.HI, bus.LO});
        end
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, busy);
        n_checks++;
        if ({bus.HI, bus.LO} !== 64'h0000_0000_8000_0000) begin
            n_fail++;
            $display("FAIL div_overflow: got %h expected 0000000080000000", {bus.HI, bus.LO});
        end
        n_checks++;
        if (bus.erro_div_zero !== 1'b0) begin
            n_fail++; $display("FAIL div_overflow_err: got %b expected 0", bus.erro_div_zero);
        end
    endtask

    task automatic test_div_zero();
        int   lat;
        logic busy;
        start_op(2'b10, 32'h1234_5678, 32'd0);
        wait_done(lat, busy);
        n_checks++;
        if (lat !== 0) begin
            n_fail++; $display("FAIL divz_latency: got %0d expected 0", lat);
        end
        n_checks++;
        if ((busy | bus.ocupado) !== 1'b0) begin
            n_fail++; $display("FAIL divz_busy: got %b expected 0", busy | bus.ocupado);
        end
        n_checks++;
        if ({bus.HI, bus.LO} !== 64'h1234_5678_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL divz_result: got %h expected 12345678ffffffff", {bus.HI, bus.LO});
        end
        n_checks++;
        if (bus.erro_div_zero !== 1'b1) begin
            n_fail++; $display("FAIL divz_err: got %b expected 1", bus.erro_div_zero);
        end
        start_op(2'b01, 32'd2, 32'd3);
        wait_done(lat, busy);
        n_checks++;
        if ({bus.HI, bus.LO, bus.erro_div_zero} !== {32'd0, 32'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL multu_after_divz: got %h/%h err %b expected 0/6 err 0",
                     bus.HI, bus.LO, bus.erro_div_zero);
        end
    endtask

    task automatic test_ignore_restart();
        int lat;
        start_op(2'b01, 32'd5, 32'd5);
        lat = 0;
        while (!bus.pronto && lat < 100) begin
            if (lat == 9) begin
                bus.iniciar = 1'b1;
                bus.Rs      = 32'd9;
                bus.Rt      = 32'd11;
            end else if (lat == 10) begin
                bus.iniciar = 1'b0;
                bus.Rs      = 32'd123;
                bus.Rt      = 32'd456;
            end
            @(negedge clock);
            lat++;
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++; $display("FAIL ignore_latency: got %0d expected 33", lat);
        end
        n_checks++;
        if ({bus.HI, bus.LO} !== {32'd0, 32'd25}) begin
            n_fail++; $display("FAIL ignore_result: got %h expected 0000000000000019",
                               {bus.HI, bus.LO});
        end
        @(negedge clock);
        n_checks++;
        if ({bus.ocupado, bus.pronto} !== 2'b00) begin
            n_fail++; $display("FAIL ignore_idle: got %b expected 00", {bus.ocupado, bus.pronto});
        end
    endtask

    task automatic test_reset_mid_op();
        int   lat;
        logic busy;
        start_op(2'b01, 32'hFFFF_FFFF, 32'd2);
        repeat (9) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.HI, bus.LO} !== 64'd0) begin
            n_fail++; $display("FAIL midreset_hilo: got %h expected 0", {bus.HI, bus.LO});
        end
        n_checks++;
        if ({bus.ocupado, bus.pronto} !== 2'b00) begin
            n_fail++; $display("FAIL midreset_flags: got %b expected 00",
                               {bus.ocupado, bus.pronto});
        end
        @(negedge clock);
        reset = 1'b1;
        start_op(2'b01, 32'd4, 32'd4);
        wait_done(lat, busy);
        n_checks++;
        if (lat !== 33) begin
            n_fail++; $display("FAIL after_reset_latency: got %0d expected 33", lat);
        end
        n_checks++;
        if ({bus.HI, bus.LO} !== {32'd0, 32'd16}) begin
            n_fail++; $display("FAIL after_reset_result: got %h expected 0000000000000010",
                               {bus.HI, bus.LO});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_multu_max();
        test_back_to_back();
        test_div_signed();
        test_div_zero();
        test_ignore_restart();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
